muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS datapath. It executes mult, multu, div, divu, mthi and mtlo. Multiply and divide are iterative: one bit per cycle, one shared 32-bit adder/subtractor. It exposes a busy/stall signal so the pipeline holds any HI/LO access until the result is committed.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_iter.sv | 104 ++++++++++
 rtl/muldiv_ctrl.sv | 116 +++++++++++
 tb/tb_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM encoding and defaults
// for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(
        input logic [2:0] op
    );
        return !op[2];
    endfunction

    function automatic logic is_div(
        input logic [2:0] op
    );
        return op[1];
    endfunction

    function automatic logic is_sgn(
        input logic [2:0] op
    );
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: pipeline <-> HI/LO sequencer request
// and result bundle.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-step shift-add / restoring
// divide datapath around a single WIDTH+1 adder.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_op,
    input  logic             sgn_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   dvs;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;

    logic [WIDTH-1:0] acc_h;
    logic [WIDTH-1:0] acc_l;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH:0]   sum;
    logic             restore;

    logic             sa;
    logic             sb;
    logic             fix_ok;
    logic [WIDTH-1:0] a_ld;
    logic [WIDTH-1:0] b_ld;

    // A zero divisor skips sign handling so HI keeps the raw dividend.
    always_comb begin
        sa     = sgn_op & a[WIDTH-1];
        sb     = sgn_op & b[WIDTH-1];
        fix_ok = !(div_op && (b == '0));
        a_ld   = (sa && fix_ok) ? -a : a;
        b_ld   = sb ? -b : b;
    end

    always_comb begin
        acc_h   = acc[2*WIDTH-1:WIDTH];
        acc_l   = acc[WIDTH-1:0];
        rsh     = {acc_h, acc_l[WIDTH-1]};
        x       = div_q ? rsh : {1'b0, acc_h};
        y       = div_q ? ~{1'b0, dvs}
                : (acc_l[0] ? {1'b0, dvs} : '0);
        sum     = x + y + (WIDTH+1)'(div_q);
        restore = sum[WIDTH];
        if (div_q) begin
            acc_nx = {restore ? rsh[WIDTH-1:0]
                              : sum[WIDTH-1:0],
                      acc_l[WIDTH-2:0], ~restore};
        end else begin
            acc_nx = {sum, acc_l[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            dvs   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            div_q <= div_op;
            neg_q <= fix_ok & (sa ^ sb);
            neg_r <= div_op & fix_ok & sa;
            if (div_op) begin
                acc <= {{WIDTH{1'b0}}, a_ld};
                dvs <= b_ld;
            end else begin
                acc <= {{WIDTH{1'b0}}, b_ld};
                dvs <= a_ld;
            end
        end else if (step) begin
            acc <= acc_nx;
        end
    end

    always_comb begin
        prod_n = -acc;
        if (div_q) begin
            res_hi = neg_r ? -acc_h : acc_h;
            res_lo = neg_q ? -acc_l : acc_l;
        end else begin
            res_hi = neg_q ? prod_n[2*WIDTH-1:WIDTH]
                           : acc_h;
            res_lo = neg_q ? prod_n[WIDTH-1:0] : acc_l;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner; sequences mult/div through
// RUN and FIX and handles mthi/mtlo and flush.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    logic load;
    logic step;
    logic commit;
    logic wr_hi;
    logic wr_lo;

    assign bus.busy = busy;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .div_op (is_div(bus.op)),
        .sgn_op (is_sgn(bus.op)),
        .a      (bus.a),
        .b      (bus.b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        commit   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        is_muldiv(bus.op): begin
                            load     = 1'b1;
                            state_nx = ST_RUN;
                        end
                        (bus.op == OP_MTHI): wr_hi = 1'b1;
                        (bus.op == OP_MTLO): wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_nx = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        state_nx = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_nx = ST_IDLE;
                commit   = !bus.flush;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != ST_IDLE);
            if (load) begin
                cnt <= CW'(WIDTH - 1);
            end else if (step && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (wr_hi) begin
                hi <= bus.a;
            end
            if (wr_lo) begin
                lo <= bus.a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors, scoreboard of
// expected HI/LO and busy length per mul/div.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        int          id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h,
                        input logic [31:0] l,
                        input int n, input int id);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.len = n;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout: busy stuck, want idle");
        end
    endtask

    task automatic run(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] h,
                       input logic [31:0] l,
                       input int id);
        push(h, l, 33, id);
        issue(o, x, y);
        wait_idle();
    endtask

    // Monitor: each busy falling edge retires one entry.
    initial begin
        exp_t e;
        int   bcnt;
        logic pbusy;
        bcnt  = 0;
        pbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                bcnt++;
            end else begin
                if (pbusy) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexp: busy fell, none due");
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("hi%0d", e.id),
                            bus.hi, e.hi);
                        chk($sformatf("lo%0d", e.id),
                            bus.lo, e.lo);
                        chk($sformatf("len%0d", e.id),
                            bcnt, e.len);
                    end
                end
                bcnt = 0;
            end
            pbusy = (bus.busy === 1'b1);
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;

        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 1);
        run(OP_MULT, 32'hFFFF_FFFD, 32'd5,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 3);
        run(OP_DIVU, 32'd7, 32'd0,
            32'd7, 32'hFFFF_FFFF, 4);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 32'h8000_0000, 5);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFF9, 32'hFFFF_FFFF, 6);
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE,
            32'd1, 32'hFFFF_FFFD, 7);
        run(OP_MULT, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'd0, 8);

        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi", bus.hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, bus.busy}, 32'd0);
        push(32'h1234_5678, 32'd0, 10, 9);
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);

        push(32'd2, 32'd14, 33, 10);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'h0000_00AA;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        issue(OP_MTLO, 32'h0000_00AA, 32'd0);
        chk("mtlo", bus.lo, 32'h0000_00AA);
        chk("mtlo_hi", bus.hi, 32'd2);

        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        chk("nop_busy", {31'b0, bus.busy}, 32'd0);
        chk("nop_hi", bus.hi, 32'd2);
        chk("nop_lo", bus.lo, 32'h0000_00AA);

        push(32'd0, 32'd0, 5, 11);
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        issue(OP_MTLO, 32'd1, 32'd0);
        chk("mrst_lo", bus.lo, 32'd1);
        chk("mrst_hi", bus.hi, 32'd0);

        run(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 12);

        repeat (3) @(negedge clk);
        chk("sb_left", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
